// File: rtl/fifo_stream_reader.sv
// Read-side engine for sync_fifo (standard mode): issues rd_en only when a skid slot is
// guaranteed, absorbs the fixed read latency and presents the words as a valid/ready stream.
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic                              sys_clk,
    input  logic                              rst,
    input  logic                              fifo_empty,
    output logic                              fifo_rd_en,
    input  logic                              fifo_valid,
    input  logic [DATA_WIDTH-1:0]             fifo_dout,
    output logic                              m_valid,
    output logic [DATA_WIDTH-1:0]             m_data,
    input  logic                              m_ready,
    output logic [$clog2(RD_LATENCY+2)-1:0]   level,
    output logic [31:0]                       word_cnt,
    output logic                              err
);

    localparam int BUF_DEPTH = RD_LATENCY + 1;
    localparam int PTR_W     = $clog2(BUF_DEPTH);
    localparam int OCC_W     = $clog2(BUF_DEPTH + 1);
    localparam int SUM_W     = OCC_W + 1;

    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(BUF_DEPTH - 1);
    localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(BUF_DEPTH);
    localparam logic [SUM_W-1:0] SUM_LIMIT = SUM_W'(BUF_DEPTH);

    logic [DATA_WIDTH-1:0] buf_mem [BUF_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [OCC_W-1:0]      occ;
    logic [OCC_W-1:0]      inflight;

    logic                  pop;
    logic                  push;
    logic                  accept;
    logic                  overflow;
    logic                  unsolicited;
    logic                  retire;
    logic [SUM_W-1:0]      credit;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign pop    = m_valid && m_ready;
    assign push   = fifo_valid;

    // Crediting the same-cycle pop is what keeps issue going at one word per cycle.
    assign credit = SUM_W'(occ) + SUM_W'(inflight) - SUM_W'(pop);

    // Gated by the reset net so the strobe drops immediately, not at the next edge.
    assign fifo_rd_en = rst && !fifo_empty && (credit < SUM_LIMIT);

    assign overflow    = push && (occ == OCC_FULL) && !pop;
    assign accept      = push && !overflow;
    assign unsolicited = push && (inflight == '0);
    assign retire      = push && (inflight != '0);

    assign m_valid = (occ != '0);
    assign m_data  = buf_mem[rd_ptr];
    assign level   = occ;

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_mem[i] <= '0;
            end
            wr_ptr <= '0;
        end else if (accept) begin
            buf_mem[wr_ptr] <= fifo_dout;
            wr_ptr          <= ptr_inc(wr_ptr);
        end
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
        end else if (pop) begin
            rd_ptr <= ptr_inc(rd_ptr);
        end
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            occ <= '0;
        end else begin
            case ({accept, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    // Stray data with nothing outstanding must not drive the count below zero.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            inflight <= '0;
        end else begin
            case ({fifo_rd_en, retire})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            word_cnt <= '0;
        end else if (pop) begin
            word_cnt <= word_cnt + 32'd1;
        end
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else if (unsolicited || overflow) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench: two readers (read latency 1 and 3), each fed by a small FIFO model.
module tb_fifo_stream_reader;

    logic sys_clk = 1'b0;
    logic rst     = 1'b0;

    always #5 sys_clk = ~sys_clk;

    // instance with RD_LATENCY = 1
    logic        empty1, rd_en1, fvalid1, m_valid1, err1;
    logic        m_ready1 = 1'b1;
    logic [7:0]  fdout1, m_data1;
    logic [1:0]  level1;
    logic [31:0] word_cnt1;

    // instance with RD_LATENCY = 3
    logic        empty3, rd_en3, fvalid3, m_valid3, err3;
    logic        m_ready3 = 1'b0;
    logic [7:0]  fdout3, m_data3;
    logic [2:0]  level3;
    logic [31:0] word_cnt3;

    fifo_stream_reader #(.DATA_WIDTH(8), .RD_LATENCY(1)) d1 (
        .sys_clk(sys_clk), .rst(rst), .fifo_empty(empty1), .fifo_rd_en(rd_en1),
        .fifo_valid(fvalid1), .fifo_dout(fdout1), .m_valid(m_valid1), .m_data(m_data1),
        .m_ready(m_ready1), .level(level1), .word_cnt(word_cnt1), .err(err1)
    );

    fifo_stream_reader #(.DATA_WIDTH(8), .RD_LATENCY(3)) d3 (
        .sys_clk(sys_clk), .rst(rst), .fifo_empty(empty3), .fifo_rd_en(rd_en3),
        .fifo_valid(fvalid3), .fifo_dout(fdout3), .m_valid(m_valid3), .m_data(m_data3),
        .m_ready(m_ready3), .level(level3), .word_cnt(word_cnt3), .err(err3)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // FIFO models: words in mem, read index advances on rd_en, data returns after the latency.
    logic [7:0] mem1 [0:1023];
    int         idx1 = 0, n1 = 0;
    logic       gate1 = 1'b0, inj1 = 1'b0;
    logic [7:0] inj_data1 = 8'h00;
    logic       vp1;
    logic [7:0] dp1;

    assign empty1  = (idx1 >= n1) || gate1;
    assign fvalid1 = vp1 | inj1;
    assign fdout1  = inj1 ? inj_data1 : dp1;

    always @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            vp1 <= 1'b0;
        end else begin
            vp1 <= rd_en1;
            dp1 <= mem1[idx1 % 1024];
            if (rd_en1) idx1 <= idx1 + 1;
        end
    end

    logic [7:0] mem3 [0:1023];
    int         idx3 = 0, n3 = 0;
    logic [2:0] vp3;
    logic [7:0] dp3 [3];

    assign empty3  = (idx3 >= n3);
    assign fvalid3 = vp3[2];
    assign fdout3  = dp3[2];

    always @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            vp3 <= 3'b000;
        end else begin
            vp3    <= {vp3[1:0], rd_en3};
            dp3[0] <= mem3[idx3 % 1024];
            dp3[1] <= dp3[0];
            dp3[2] <= dp3[1];
            if (rd_en3) idx3 <= idx3 + 1;
        end
    end

    logic [7:0] q1[$];
    logic [7:0] q3[$];

    task automatic load1(input int k, input int base, input int step);
        for (int i = 0; i < k; i++) begin
            mem1[n1 % 1024] = 8'(base + i * step);
            q1.push_back(8'(base + i * step));
            n1++;
        end
    endtask

    task automatic load3(input int k, input int base, input int step);
        for (int i = 0; i < k; i++) begin
            mem3[n3 % 1024] = 8'(base + i * step);
            q3.push_back(8'(base + i * step));
            n3++;
        end
    endtask

    // Output monitors: transfers pop the scoreboard; stalls must hold the word.
    logic       stall1 = 1'b0, stall3 = 1'b0;
    logic [7:0] hold1, hold3;

    always @(negedge sys_clk) begin
        if (!rst) begin
            stall1 = 1'b0;
        end else begin
            if (empty1) chk("rd_en_while_empty1", 32'(rd_en1), 32'd0);
            chk("level_bound1", 32'(level1 <= 2'd2), 32'd1);
            if (stall1) begin
                chk("hold_valid1", 32'(m_valid1), 32'd1);
                chk("hold_data1", 32'(m_data1), 32'(hold1));
            end
            if (m_valid1 && m_ready1) begin
                chk("word_expected1", 32'(q1.size() != 0), 32'd1);
                if (q1.size() != 0) chk("data1", 32'(m_data1), 32'(q1.pop_front()));
            end
            stall1 = m_valid1 && !m_ready1;
            hold1  = m_data1;
        end
    end

    always @(negedge sys_clk) begin
        if (!rst) begin
            stall3 = 1'b0;
        end else begin
            if (empty3) chk("rd_en_while_empty3", 32'(rd_en3), 32'd0);
            chk("level_bound3", 32'(level3 <= 3'd4), 32'd1);
            if (stall3) begin
                chk("hold_valid3", 32'(m_valid3), 32'd1);
                chk("hold_data3", 32'(m_data3), 32'(hold3));
            end
            if (m_valid3 && m_ready3) begin
                chk("word_expected3", 32'(q3.size() != 0), 32'd1);
                if (q3.size() != 0) chk("data3", 32'(m_data3), 32'(q3.pop_front()));
            end
            stall3 = m_valid3 && !m_ready3;
            hold3  = m_data3;
        end
    end

    task automatic drain1(input int max_cyc);
        int k;
        for (k = 0; k < max_cyc; k++) begin
            @(negedge sys_clk);
            if (q1.size() == 0 && !m_valid1 && idx1 >= n1 && !vp1) break;
        end
        chk("drain1_done", 32'(k < max_cyc), 32'd1);
        @(posedge sys_clk); #1;
    endtask

    task automatic drain3(input int max_cyc);
        int k;
        for (k = 0; k < max_cyc; k++) begin
            @(posedge sys_clk); #1;
            m_ready3 = ~m_ready3;
            @(negedge sys_clk);
            if (q3.size() == 0 && !m_valid3 && idx3 >= n3 && vp3 == 3'b000) break;
        end
        chk("drain3_done", 32'(k < max_cyc), 32'd1);
        @(posedge sys_clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int maxlvl;

        // reset values with a non-empty FIFO
        load1(16, 0, 1);
        #3;
        chk("rst_rd_en1", 32'(rd_en1), 32'd0);
        chk("rst_m_valid1", 32'(m_valid1), 32'd0);
        chk("rst_m_data1", 32'(m_data1), 32'd0);
        chk("rst_level1", 32'(level1), 32'd0);
        chk("rst_word_cnt1", word_cnt1, 32'd0);
        chk("rst_err1", 32'(err1), 32'd0);
        chk("rst_m_valid3", 32'(m_valid3), 32'd0);
        chk("rst_word_cnt3", word_cnt3, 32'd0);
        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_rd_en1_clocked", 32'(rd_en1), 32'd0);
        rst = 1'b1;
        #1;
        chk("rd_en_after_release", 32'(rd_en1), 32'd1);

        // streaming at full rate, latency 1
        for (k = 0; k < 20; k++) begin
            @(negedge sys_clk);
            if (m_valid1) break;
        end
        chk("first_word_lat1", 32'(k), 32'd2);
        for (int i = 0; i < 16; i++) begin
            chk("stream_valid1", 32'(m_valid1), 32'd1);
            if (i < 15) @(negedge sys_clk);
        end
        @(negedge sys_clk);
        chk("stream_end1", 32'(m_valid1), 32'd0);
        chk("stream_word_cnt1", word_cnt1, 32'd16);
        chk("stream_err1", 32'(err1), 32'd0);
        chk("stream_left1", 32'(q1.size()), 32'd0);
        @(posedge sys_clk); #1;

        // backpressure: ready low for stream cycles 5..12
        load1(16, 8'h10, 1);
        maxlvl = 0;
        for (int c = 0; c < 30; c++) begin
            m_ready1 = !(c >= 5 && c <= 12);
            @(negedge sys_clk);
            if (c == 5)  chk("rd_en_credit_full", 32'(rd_en1), 32'd0);
            if (c == 13) chk("rd_en_resume", 32'(rd_en1), 32'd1);
            if (level1 == 2'd2 && !m_ready1) chk("rd_en_saturated", 32'(rd_en1), 32'd0);
            if (int'(level1) > maxlvl) maxlvl = int'(level1);
            @(posedge sys_clk); #1;
        end
        m_ready1 = 1'b1;
        chk("level_peak1", 32'(maxlvl), 32'd2);
        drain1(50);
        chk("bp_word_cnt1", word_cnt1, 32'd32);
        chk("bp_err1", 32'(err1), 32'd0);

        // latency 3, 64 words, ready toggling every cycle
        m_ready3 = 1'b1;
        load3(64, 3, 7);
        for (k = 0; k < 20; k++) begin
            @(negedge sys_clk);
            if (m_valid3) break;
        end
        chk("first_word_lat3", 32'(k), 32'd4);
        drain3(400);
        chk("lat3_word_cnt", word_cnt3, 32'd64);
        chk("lat3_err", 32'(err3), 32'd0);
        chk("lat3_left", 32'(q3.size()), 32'd0);

        // unsolicited data sets the sticky error
        m_ready1  = 1'b1;
        inj_data1 = 8'hA5;
        inj1      = 1'b1;
        q1.push_back(8'hA5);
        @(posedge sys_clk); #1;
        inj1 = 1'b0;
        @(negedge sys_clk);
        chk("err_unsolicited", 32'(err1), 32'd1);
        @(posedge sys_clk); #1;
        load1(8, 8'h80, 1);
        repeat (4) @(posedge sys_clk);
        #1;
        chk("err_sticky", 32'(err1), 32'd1);

        // asynchronous reset mid-burst
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_rd_en", 32'(rd_en1), 32'd0);
        chk("mid_rst_m_valid", 32'(m_valid1), 32'd0);
        chk("mid_rst_m_data", 32'(m_data1), 32'd0);
        chk("mid_rst_level", 32'(level1), 32'd0);
        chk("mid_rst_word_cnt", word_cnt1, 32'd0);
        chk("mid_rst_err", 32'(err1), 32'd0);
        n1 = idx1;
        q1.delete();
        repeat (2) @(posedge sys_clk);
        #1;
        rst = 1'b1;
        load1(4, 8'hC0, 3);
        drain1(40);
        chk("post_rst_word_cnt", word_cnt1, 32'd4);
        chk("post_rst_err", 32'(err1), 32'd0);

        // word counter wrap
        force d1.word_cnt = 32'hFFFF_FFFF;
        #1;
        release d1.word_cnt;
        #1;
        chk("cnt_preset", word_cnt1, 32'hFFFF_FFFF);
        load1(1, 8'h5A, 1);
        drain1(20);
        chk("cnt_wrap", word_cnt1, 32'd0);

        // empty flag toggling every cycle
        gate1 = 1'b1;
        load1(20, 8'h20, 5);
        for (int c = 0; c < 80; c++) begin
            @(posedge sys_clk); #1;
            gate1 = ~gate1;
        end
        gate1 = 1'b0;
        drain1(40);
        chk("toggle_word_cnt", word_cnt1, 32'd20);
        chk("toggle_err", 32'(err1), 32'd0);
        chk("toggle_left", 32'(q1.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
